mipi_csi_tx_packet_encoder_16b2lane: RTL and testbench

- Transmit-side CSI-2 packet builder for the 16-bit-gear, 2-lane datapath: one 32-bit word per clock, the same lane/byte layout the RX decoder consumes.
- Takes a packet request (VC, data type, word count) plus payload words, and emits a lane-interleaved stream: per-lane sync byte, packet header with ECC, payload, CRC-16 footer.
- Sits between the pixel packer and the D-PHY TX serializers. The output has no backpressure, so the serializer consumes every valid word.

---
 rtl/mipi_csi_pkg.sv | 38 +++
 rtl/mipi_csi_crc16_32b.sv | 19 +
 rtl/mipi_csi_tx_packet_encoder_16b2lane.sv | 151 +++++++++++++++
 tb/tb_mipi_csi_tx_packet_encoder_16b2lane.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 constants, data types, FSM encoding and the packet-header ECC helper.
// Used by the TX encoder and by any RX-side header checker.
package mipi_csi_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hB8;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] DT_RAW12    = 6'h2C;
  localparam logic [5:0] DT_RAW14    = 6'h2D;
  localparam logic [5:0] DT_LONG_MIN = 6'h10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_PAY    = 3'd2,
    ST_FTR    = 3'd3,
    ST_SHORT2 = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  // Each mask selects the header bits (D0 = DI bit 0) covered by one parity bit.
  function automatic logic [7:0] csi_ecc(input logic [23:0] d);
    logic [7:0] e;
    e[0] = ^(d & 24'hF12CB7);
    e[1] = ^(d & 24'hF2555B);
    e[2] = ^(d & 24'h749A6D);
    e[3] = ^(d & 24'hB8E38E);
    e[4] = ^(d & 24'hDF03F0);
    e[5] = ^(d & 24'hEFFC00);
    e[7:6] = 2'b00;
    return e;
  endfunction

endpackage

// File: rtl/mipi_csi_crc16_32b.sv
// Combinational CRC-16 (reflected 0x8408) advance over one 32-bit word, byte [7:0] first, LSB first.
// Zero latency; no flow control.
module mipi_csi_crc16_32b (
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    logic [15:0] c;
    c = crc_i;
    for (int i = 0; i < 32; i++) begin
      if (c[0] ^ data_i[i]) c = (c >> 1) ^ 16'h8408;
      else                  c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/mipi_csi_tx_packet_encoder_16b2lane.sv
// CSI-2 TX packet builder (16-bit gear, 2 lanes): sync, header+ECC, payload, CRC-16 footer.
// First word one cycle after accept; output never stalls, so payload is pulled purely by state.
module mipi_csi_tx_packet_encoder_16b2lane
  import mipi_csi_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        pkt_valid_i,
  output logic        pkt_ready_o,
  input  logic [1:0]  pkt_vc_i,
  input  logic [5:0]  pkt_data_type_i,
  input  logic [15:0] pkt_word_count_i,
  input  logic [31:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [31:0] data_o,
  output logic        output_valid_o,
  output logic        busy_o,
  output logic        underrun_o,
  output logic        length_error_o
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state, state_n;
  logic [13:0] cnt_q, cnt_n;
  logic [15:0] hold_q, hold_n;
  logic [15:0] crc_q, crc_n, crc_upd;
  logic [7:0]  gap_q, gap_n;
  logic [7:0]  wchi_q, wchi_n;
  logic [7:0]  ecc_q, ecc_n;
  logic [31:0] data_n;
  logic [31:0] word_in;
  logic        valid_n, busy_n, len_err_n;
  logic [7:0]  di;
  logic        is_long, len_bad;

  assign di      = {pkt_vc_i, pkt_data_type_i};
  assign is_long = (pkt_data_type_i >= DT_LONG_MIN);
  assign len_bad = is_long && ((pkt_word_count_i == 16'd0) || (pkt_word_count_i[1:0] != 2'd0));

  assign pkt_ready_o  = (state == ST_IDLE);
  assign data_ready_o = (state == ST_HDR) || (state == ST_PAY);
  assign underrun_o   = data_ready_o && !data_valid_i;
  // A missing word is replaced by zeros so the footer still matches what was sent.
  assign word_in      = data_valid_i ? data_i : 32'd0;

  mipi_csi_crc16_32b u_crc (
    .crc_i  (crc_q),
    .data_i (word_in),
    .crc_o  (crc_upd)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt_q;
    hold_n    = hold_q;
    crc_n     = crc_q;
    gap_n     = gap_q;
    wchi_n    = wchi_q;
    ecc_n     = ecc_q;
    data_n    = 32'd0;
    valid_n   = 1'b0;
    len_err_n = 1'b0;

    case (state)
      ST_IDLE: begin
        crc_n = 16'hFFFF;
        if (pkt_valid_i) begin
          wchi_n = pkt_word_count_i[15:8];
          ecc_n  = csi_ecc({pkt_word_count_i, di});
          cnt_n  = pkt_word_count_i[15:2];
          if (len_bad) begin
            len_err_n = 1'b1;
            gap_n     = GAP_LOAD;
            state_n   = ST_GAP;
          end else begin
            data_n  = {pkt_word_count_i[7:0], SYNC_BYTE, di, SYNC_BYTE};
            valid_n = 1'b1;
            state_n = is_long ? ST_HDR : ST_SHORT2;
          end
        end
      end

      ST_HDR, ST_PAY: begin
        // Lane0 takes even payload bytes, lane1 odd; the upper half waits one word.
        if (state == ST_HDR) data_n = {word_in[15:8], ecc_q, word_in[7:0], wchi_q};
        else                 data_n = {word_in[15:8], hold_q[15:8], word_in[7:0], hold_q[7:0]};
        valid_n = 1'b1;
        hold_n  = word_in[31:16];
        crc_n   = crc_upd;
        cnt_n   = cnt_q - 14'd1;
        state_n = (cnt_q == 14'd1) ? ST_FTR : ST_PAY;
      end

      ST_FTR: begin
        data_n  = {crc_q[15:8], hold_q[15:8], crc_q[7:0], hold_q[7:0]};
        valid_n = 1'b1;
        gap_n   = GAP_LOAD;
        state_n = ST_GAP;
      end

      ST_SHORT2: begin
        data_n  = {8'h00, ecc_q, 8'h00, wchi_q};
        valid_n = 1'b1;
        gap_n   = GAP_LOAD;
        state_n = ST_GAP;
      end

      ST_GAP: begin
        if (gap_q == 8'd0) state_n = ST_IDLE;
        else               gap_n   = gap_q - 8'd1;
      end

      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= ST_IDLE;
      cnt_q          <= '0;
      hold_q         <= '0;
      crc_q          <= '0;
      gap_q          <= '0;
      wchi_q         <= '0;
      ecc_q          <= '0;
      data_o         <= '0;
      output_valid_o <= 1'b0;
      busy_o         <= 1'b0;
      length_error_o <= 1'b0;
    end else begin
      state          <= state_n;
      cnt_q          <= cnt_n;
      hold_q         <= hold_n;
      crc_q          <= crc_n;
      gap_q          <= gap_n;
      wchi_q         <= wchi_n;
      ecc_q          <= ecc_n;
      data_o         <= data_n;
      output_valid_o <= valid_n;
      busy_o         <= busy_n;
      length_error_o <= len_err_n;
    end
  end

endmodule

// File: tb/tb_mipi_csi_tx_packet_encoder_16b2lane.sv
// Bench for the CSI-2 TX packet encoder: short-packet vector table, long packets against a
// lane-map/CRC/ECC model through a scoreboard, length errors, underrun, back-to-back and reset.
module tb_mipi_csi_tx_packet_encoder_16b2lane;
  import mipi_csi_pkg::*;

  localparam int G = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b1;
  logic        pkt_valid_i = 1'b0;
  logic        pkt_ready_o;
  logic [1:0]  pkt_vc_i = '0;
  logic [5:0]  pkt_data_type_i = '0;
  logic [15:0] pkt_word_count_i = '0;
  logic [31:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        data_ready_o;
  logic [31:0] data_o;
  logic        output_valid_o;
  logic        busy_o;
  logic        underrun_o;
  logic        length_error_o;

  mipi_csi_tx_packet_encoder_16b2lane #(.GAP_CYCLES(G)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .pkt_valid_i      (pkt_valid_i),
    .pkt_ready_o      (pkt_ready_o),
    .pkt_vc_i         (pkt_vc_i),
    .pkt_data_type_i  (pkt_data_type_i),
    .pkt_word_count_i (pkt_word_count_i),
    .data_i           (data_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .data_o           (data_o),
    .output_valid_o   (output_valid_o),
    .busy_o           (busy_o),
    .underrun_o       (underrun_o),
    .length_error_o   (length_error_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b1;
  logic [31:0] exp_q[$];
  logic [31:0] seen[$];
  int          vtimes[$];
  logic [7:0]  pay[0:4095];
  logic [7:0]  mb[0:4095];
  logic [7:0]  qb[0:4199];

  typedef struct {
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [31:0] w0;
    logic [31:0] w1;
  } svec_t;
  svec_t tv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (mon_en && rst_n_i) begin
      if (output_valid_o) begin
        seen.push_back(data_o);
        vtimes.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_word", data_o, 32'hxxxxxxxx);
        else check("stream_word", data_o, exp_q.pop_front());
      end else begin
        check("idle_data", data_o, 32'd0);
      end
    end
  end

  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    logic [5:0] col[24];
    logic [5:0] e;
    col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
            6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
            6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e = e ^ col[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] crc_model(input int n);
    logic [15:0] c;
    logic [7:0]  x;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      x = mb[i] ^ c[7:0];
      x = x ^ {x[3:0], 4'h0};
      c = {8'h00, c[15:8]} ^ {x, 8'h00} ^ {5'b0, x, 3'b0} ^ {12'b0, x[7:4]};
    end
    return c;
  endfunction

  function automatic logic [7:0] lane_byte(input int lane, input int j, input int nq);
    int idx;
    if (j == 0) return 8'hB8;
    idx = 2 * (j - 1) + lane;
    return (idx < nq) ? qb[idx] : 8'h00;
  endfunction

  task automatic push_expected(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                               input int drop);
    logic [7:0]  di;
    logic [15:0] c;
    int          w, nq, nw;
    di = {vc, dt};
    w  = int'(wc);
    qb[0] = di; qb[1] = wc[7:0]; qb[2] = wc[15:8]; qb[3] = ecc_model({wc, di});
    nq = 4; nw = 2;
    if (dt >= 6'h10) begin
      for (int p = 0; p < w; p++) begin
        mb[p]     = (p / 4 == drop) ? 8'h00 : pay[p];
        qb[4 + p] = mb[p];
      end
      c = crc_model(w);
      qb[4 + w] = c[7:0];
      qb[5 + w] = c[15:8];
      nq = 6 + w;
      nw = w / 4 + 2;
    end
    for (int i = 0; i < nw; i++)
      exp_q.push_back({lane_byte(1, 2*i+1, nq), lane_byte(1, 2*i, nq),
                       lane_byte(0, 2*i+1, nq), lane_byte(0, 2*i, nq)});
  endtask

  task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                          input int drop);
    bit is_long, err, done;
    int nw_in, exp_n, n, k;
    is_long = (dt >= 6'h10);
    err     = is_long && (wc == 16'd0 || wc[1:0] != 2'd0);
    nw_in   = (is_long && !err) ? int'(wc) / 4 : 0;
    exp_n   = !is_long ? G + 2 : (err ? G + 1 : nw_in + 2 + G);
    if (!err) push_expected(vc, dt, wc, drop);
    seen.delete();
    @(posedge clk_i); #1;
    pkt_valid_i = 1'b1; pkt_vc_i = vc; pkt_data_type_i = dt; pkt_word_count_i = wc;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk_i);
      if (pkt_ready_o) done = 1'b1;
    end
    if (!done) begin
      check("accept_timeout", 32'd0, 32'd1);
      pkt_valid_i = 1'b0;
      return;
    end
    @(posedge clk_i); #1;
    pkt_valid_i = 1'b0;
    done = 1'b0; n = 0;
    while (!done && n < 5000) begin
      n++;
      k = n - 1;
      if (n <= nw_in) begin
        data_i       = {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]};
        data_valid_i = (k != drop);
        if (k == drop) data_i = $urandom;
      end else begin
        data_i       = $urandom;
        data_valid_i = 1'b1;
      end
      @(negedge clk_i);
      if (n == 1) begin
        check("busy_after_accept", {31'd0, busy_o}, 32'd1);
        check("length_error_pulse", {31'd0, length_error_o}, {31'd0, err});
      end
      if (n == 2) check("length_error_clear", {31'd0, length_error_o}, 32'd0);
      check("data_ready", {31'd0, data_ready_o}, {31'd0, n <= nw_in});
      check("underrun", {31'd0, underrun_o}, {31'd0, (n <= nw_in) && (k == drop)});
      if (pkt_ready_o) done = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("ready_return_cycle", n, exp_n);
    check("scoreboard_drain", exp_q.size(), 32'd0);
    data_valid_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_o"}, data_o, 32'd0);
    check({tag, "_valid"}, {31'd0, output_valid_o}, 32'd0);
    check({tag, "_pkt_ready"}, {31'd0, pkt_ready_o}, 32'd1);
    check({tag, "_data_ready"}, {31'd0, data_ready_o}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_underrun"}, {31'd0, underrun_o}, 32'd0);
    check({tag, "_length_error"}, {31'd0, length_error_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    int n;
    logic [7:0] vec10[24];

    tv[0] = '{2'd0, DT_FS, 16'h0000, 32'h00B800B8, 32'h00000000};
    tv[1] = '{2'd1, DT_LS, 16'h0001, 32'h01B842B8, 32'h00070000};
    tv[2] = '{2'd3, DT_FE, 16'h1234, 32'h34B8C1B8, 32'h00090012};
    tv[3] = '{2'd2, DT_LE, 16'hFFFF, 32'hFFB883B8, 32'h002F00FF};
    vec10 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
              8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    #1 rst_n_i = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("after_reset");

    for (int i = 0; i < 4; i++) begin
      send_pkt(tv[i].vc, tv[i].dt, tv[i].wc, -1);
      check("short_word_count", seen.size(), 32'd2);
      check("short_w0", seen[0], tv[i].w0);
      check("short_w1", seen[1], tv[i].w1);
    end

    for (int i = 0; i < 24; i++) pay[i] = vec10[i];
    send_pkt(2'd0, DT_RAW10, 16'd24, -1);
    check("raw10_words", seen.size(), 32'd8);
    check("raw10_crc_lo", {24'd0, seen[7][15:8]}, 32'hF0);
    check("raw10_crc_hi", {24'd0, seen[7][31:24]}, 32'h00);

    for (int i = 0; i < 4096; i++) pay[i] = 8'($urandom_range(0, 255));
    send_pkt(2'd0, 6'h37, 16'h01F0, -1);
    check("hdr37_ecc", {24'd0, seen[1][23:16]}, 32'h3F);

    send_pkt(2'd1, DT_RAW12, 16'h0A00, -1);
    check("raw12_words", seen.size(), 32'd642);

    send_pkt(2'd2, DT_RAW14, 16'd4, -1);
    check("wc4_words", seen.size(), 32'd3);

    send_pkt(2'd0, DT_RAW10, 16'd16, 3);
    check("underrun_words", seen.size(), 32'd6);
    check("underrun_p12_p13", {16'd0, seen[4][31:24], seen[4][15:8]}, 32'd0);
    check("underrun_p14_p15", {16'd0, seen[5][23:16], seen[5][7:0]}, 32'd0);

    send_pkt(2'd0, DT_RAW10, 16'd6, -1);
    check("wc6_no_output", seen.size(), 32'd0);
    send_pkt(2'd3, DT_RAW12, 16'd0, -1);
    check("wc0_no_output", seen.size(), 32'd0);

    // Back-to-back: request held high through the gap is taken the cycle IDLE returns.
    push_expected(2'd0, DT_FS, 16'h0000, -1);
    push_expected(2'd1, DT_FS, 16'h0005, -1);
    vtimes.delete();
    @(posedge clk_i); #1;
    pkt_valid_i = 1'b1; pkt_vc_i = 2'd0; pkt_data_type_i = DT_FS; pkt_word_count_i = 16'h0000;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    pkt_vc_i = 2'd1; pkt_word_count_i = 16'h0005;
    done = 1'b0; n = 0;
    while (!done && n < 100) begin
      n++;
      @(negedge clk_i);
      if (pkt_ready_o) done = 1'b1;
    end
    check("b2b_accept_cycle", n, G + 2);
    @(posedge clk_i); #1;
    pkt_valid_i = 1'b0;
    repeat (G + 4) @(negedge clk_i);
    check("b2b_valid_words", vtimes.size(), 32'd4);
    check("b2b_gap", vtimes[2] - vtimes[1], G + 1);
    check("b2b_drain", exp_q.size(), 32'd0);

    // Reset in the middle of a long payload.
    mon_en = 1'b0;
    @(posedge clk_i); #1;
    pkt_valid_i = 1'b1; pkt_vc_i = 2'd0; pkt_data_type_i = DT_RAW10; pkt_word_count_i = 16'd64;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    pkt_valid_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      data_i = {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]};
      data_valid_i = 1'b1;
      @(posedge clk_i); #1;
    end
    check("pre_reset_valid", {31'd0, output_valid_o}, 32'd1);
    check("pre_reset_busy", {31'd0, busy_o}, 32'd1);
    data_valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    check_reset_outputs("post_release");
    exp_q.delete();
    mon_en = 1'b1;
    send_pkt(2'd0, DT_FS, 16'h0000, -1);
    check("post_reset_fs_w0", seen[0], 32'h00B800B8);
    check("post_reset_fs_w1", seen[1], 32'h00000000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
